// File: rtl/multiplier_pkg.sv
// Shared types and sizing for the iterative signed multiplier.
package multiplier_pkg;

    localparam int unsigned SIZE_DATA = 8;

    typedef enum logic [1:0] {
        MULT_IDLE,
        MULT_RUN,
        MULT_DONE
    } mult_state_t;

    localparam int unsigned MULT_CNT_W = $clog2(SIZE_DATA + 1);

endpackage

// File: rtl/multiplier.sv
// Iterative signed shift-add multiplier, one radix-2 step per clock, valid/ready on both sides.
// Magnitudes are multiplied unsigned and the sign is applied once when the product is registered.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SIZE_DATA
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     multiplicand,
    input  logic [DATA_WIDTH-1:0]     multiplier_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    mult_state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0]     mag_a_q, mag_b_q;
    logic                      neg_q;
    logic [2*DATA_WIDTH-1:0]   acc_q;
    logic [CntW-1:0]           cnt_q;
    logic [2*DATA_WIDTH-1:0]   product_q;
    logic                      in_ready_q;

    logic                      accept;
    logic                      last_step;
    logic [DATA_WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [DATA_WIDTH:0]       sum;
    logic [2*DATA_WIDTH-1:0]   acc_step;

    assign accept    = (state_q == MULT_IDLE) && in_valid && in_ready_q;
    // acc_q holds the complete magnitude product once DATA_WIDTH steps have run.
    assign last_step = (cnt_q == CntW'(DATA_WIDTH));

    // |-2^(N-1)| wraps back to 2^(N-1), which is exact as an unsigned N-bit value.
    always_comb begin
        mag_a_in = multiplicand[DATA_WIDTH-1]  ? (~multiplicand + 1'b1)  : multiplicand;
        mag_b_in = multiplier_in[DATA_WIDTH-1] ? (~multiplier_in + 1'b1) : multiplier_in;
    end

    // Conditional add into the upper half with carry, then shift {carry, acc} right by one.
    always_comb begin
        sum      = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + (mag_b_q[0] ? {1'b0, mag_a_q} : {(DATA_WIDTH+1){1'b0}});
        acc_step = {sum, acc_q[DATA_WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MULT_IDLE: if (accept)    state_d = MULT_RUN;
            MULT_RUN:  if (last_step) state_d = MULT_DONE;
            MULT_DONE: if (out_ready) state_d = MULT_IDLE;
            default:                  state_d = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MULT_IDLE;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == MULT_IDLE);
            unique case (state_q)
                MULT_IDLE: begin
                    if (accept) begin
                        mag_a_q <= mag_a_in;
                        mag_b_q <= mag_b_in;
                        neg_q   <= multiplicand[DATA_WIDTH-1] ^ multiplier_in[DATA_WIDTH-1];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                MULT_RUN: begin
                    if (last_step) begin
                        product_q <= neg_q ? (~acc_q + 1'b1) : acc_q;
                    end else begin
                        acc_q   <= acc_step;
                        mag_b_q <= mag_b_q >> 1;
                        cnt_q   <= cnt_q + CntW'(1);
                    end
                end
                MULT_DONE: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q == MULT_DONE);
        product   = product_q;
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier (8-bit): vector table, handshake corner cases, random soak.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;

    multiplier #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .multiplicand  (multiplicand),
        .multiplier_in (multiplier_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .product       (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_xfer = 0;
    logic        rand_run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed output transfer pops the oldest expected product.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) check("xfer_unexpected", 32'(product), 32'hDEAD_BEEF);
            else                   check("xfer_product", 32'(product), 32'(exp_q.pop_front()));
        end
    end

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        multiplicand  = a;
        multiplier_in = b;
        in_valid      = 1'b1;
        exp_q.push_back(exp);
        n_acc++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_xfer_out_valid", 32'(out_valid), 32'd0);
        check("post_xfer_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Random downstream stall while the soak runs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_run) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int cyc;
        vecs[0] = '{"3x5",        8'd3,    8'd5,    16'h000F};
        vecs[1] = '{"m7x6",       8'hF9,   8'd6,    16'hFFD6};
        vecs[2] = '{"m128xm128",  8'h80,   8'h80,   16'h4000};
        vecs[3] = '{"0xm1",       8'd0,    8'hFF,   16'h0000};
        vecs[4] = '{"127x127",    8'd127,  8'd127,  16'h3F01};
        vecs[5] = '{"m128x127",   8'h80,   8'd127,  16'hC080};
        vecs[6] = '{"1xm1",       8'd1,    8'hFF,   16'hFFFF};
        vecs[7] = '{"m1xm1",      8'hFF,   8'hFF,   16'h0001};
        vecs[8] = '{"m128x1",     8'h80,   8'd1,    16'hFF80};
        vecs[9] = '{"m5x0",       8'hFB,   8'd0,    16'h0000};

        // Reset held: everything quiet.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        reset = 1'b1;
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_out(cyc);
            check({vecs[i].name, "_latency"}, 32'(cyc), 32'd9);
            check(vecs[i].name, 32'(product), 32'(vecs[i].exp));
            drain();
        end

        // Downstream stall: output frozen for 5 cycles, no new accept.
        accept(8'd3, 8'd5, 16'h000F);
        wait_out(cyc);
        for (int k = 0; k < 5; k++) begin
            check("stall_product", 32'(product), 32'h000F);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        drain();

        // in_valid kept high with changing data while busy: ignored.
        begin
            int n = 0;
            while (!in_ready && n < 50) begin tick(); n++; end
            multiplicand  = 8'd5;
            multiplier_in = 8'd7;
            in_valid      = 1'b1;
            exp_q.push_back(16'h0023);
            tick();
            n = 0;
            while (!out_valid && n < 40) begin
                multiplicand  = 8'($urandom);
                multiplier_in = 8'($urandom);
                tick();
                n++;
            end
            in_valid = 1'b0;
            check("busy_ignore_product", 32'(product), 32'h0023);
            drain();
        end

        // Reset during RUN aborts with no output.
        accept(8'd9, 8'd9, 16'h0051);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        accept(8'd2, 8'hFD, 16'hFFFA);
        wait_out(cyc);
        check("after_abort_latency", 32'(cyc), 32'd9);
        check("after_abort_product", 32'(product), 32'hFFFA);
        drain();

        // Random soak with random out_ready.
        n_acc    = 0;
        n_xfer   = 0;
        rand_run = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            logic signed [7:0]  sa, sb;
            logic signed [15:0] e;
            sa = 8'($urandom);
            sb = 8'($urandom);
            e  = sa * sb;
            accept(sa, sb, e);
        end
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
        end
        rand_run  = 1'b0;
        out_ready = 1'b0;
        tick();
        check("soak_queue_empty", 32'(exp_q.size()), 32'd0);
        check("soak_xfer_count", 32'(n_xfer), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
